// File: rtl/servo_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : servo_ctl                                                    |
// | Description : Hobby-servo PWM generator with two arbitrated position       |
// |               requesters (manual has priority over auto) and a per-frame   |
// |               slew limit on the driven position.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module servo_ctl #(
  parameter int unsigned PERIOD = 250000,
  parameter int unsigned MIN_PW = 12500,
  parameter int unsigned STEP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_m,
  input  logic [7:0] pos_m,
  output logic       ack_m,
  input  logic       req_a,
  input  logic [7:0] pos_a,
  output logic       ack_a,
  output logic       pwm,
  output logic [7:0] cur_pos,
  output logic       busy,
  output logic [1:0] state
);

  // Counter wide enough for PERIOD-1; PERIOD > 257 guarantees at least 9 bits,
  // so MIN_PW + cur_pos always fits.
  localparam int unsigned CNT_W = $clog2(PERIOD);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] C_MIN_PW   = CNT_W'(MIN_PW);
  localparam logic [8:0]       C_STEP_9   = 9'(STEP);
  localparam logic [7:0]       C_STEP_8   = 8'(STEP);
  localparam logic [7:0]       C_CENTER   = 8'd128;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PULSE = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;
  logic [7:0]       cur_pos_q, cur_pos_d;
  logic [7:0]       tgt_q, tgt_d;

  logic             w_load;
  logic             w_ack_m;
  logic             w_ack_a;
  logic [7:0]       w_tgt_new;
  logic signed [8:0] w_diff;
  logic [8:0]       w_mag;
  logic [7:0]       w_pos_next;
  logic [CNT_W-1:0] w_pulse_end;

  // Arbitration: requests only count in LOAD; manual wins a tie and auto stays pending.
  assign w_load    = (state_q == S_LOAD);
  assign w_ack_m   = w_load & req_m;
  assign w_ack_a   = w_load & req_a & ~req_m;
  assign w_tgt_new = w_ack_m ? pos_m : (w_ack_a ? pos_a : tgt_q);

  // Last PULSE count value; cur_pos is stable for the whole frame after LOAD.
  assign w_pulse_end = C_MIN_PW + CNT_W'(cur_pos_q);

  // Slew limiter: 9-bit signed distance so 0<->255 neither wraps nor overshoots.
  always_comb begin
    w_diff     = $signed({1'b0, w_tgt_new}) - $signed({1'b0, cur_pos_q});
    w_mag      = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
    w_pos_next = w_tgt_new;
    if (w_mag > C_STEP_9) begin
      if (w_diff[8]) w_pos_next = cur_pos_q - C_STEP_8;
      else           w_pos_next = cur_pos_q + C_STEP_8;
    end
  end

  // Frame sequencer: next state, counter, target/position update and pwm level.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    cur_pos_d = cur_pos_q;

    if (state_q != S_IDLE) begin
      cnt_d = (cnt_q == C_CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        tgt_d     = w_tgt_new;
        cur_pos_d = w_pos_next;
        state_d   = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == w_pulse_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == C_CNT_LAST) state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    // pwm is registered from the next state so it is high exactly in PULSE cycles.
    pwm_d = (state_d == S_PULSE);
  end

  // State register with synchronous reset to the centred, idle condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pwm_q     <= 1'b0;
      cur_pos_q <= C_CENTER;
      tgt_q     <= C_CENTER;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pwm_q     <= pwm_d;
      cur_pos_q <= cur_pos_d;
      tgt_q     <= tgt_d;
    end
  end

  assign ack_m   = w_ack_m;
  assign ack_a   = w_ack_a;
  assign pwm     = pwm_q;
  assign cur_pos = cur_pos_q;
  assign busy    = (cur_pos_q != tgt_q);
  assign state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_servo_ctl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_servo_ctl                                                 |
// | Description : Frame-level self-checking bench for servo_ctl.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_servo_ctl;

  localparam int P  = 400;
  localparam int MW = 50;
  localparam int ST = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_m = 1'b0;
  logic [7:0] pos_m = 8'd0;
  logic       req_a = 1'b0;
  logic [7:0] pos_a = 8'd0;
  logic       ack_m, ack_a, pwm, busy;
  logic [7:0] cur_pos;
  logic [1:0] state;

  servo_ctl #(.PERIOD(P), .MIN_PW(MW), .STEP(ST)) dut (
    .clk(clk), .rst(rst),
    .req_m(req_m), .pos_m(pos_m), .ack_m(ack_m),
    .req_a(req_a), .pos_a(pos_a), .ack_a(ack_a),
    .pwm(pwm), .cur_pos(cur_pos), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit       do_rst;   // reset before this frame
    bit       mid_rst;  // assert rst at cnt=100 of this frame
    bit       rm;       // raise manual request
    logic [7:0] pm;
    bit       ra;       // raise auto request
    logic [7:0] pa;
    bit       chg;      // change pos_a one cycle before LOAD
    logic [7:0] pa2;
    bit       e_am;
    bit       e_aa;
    logic [7:0] e_cur;
    bit       e_busy;
    int       e_hi;     // expected pwm high cycles (from cnt=1)
  } row_t;

  row_t tbl[$];
  row_t sb[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic row_t mk(bit dr, bit mr, bit rm, int pm, bit ra, int pa,
                              bit chg, int pa2, bit eam, bit eaa, int ecur,
                              bit eb, int ehi);
    row_t r;
    r.do_rst = dr; r.mid_rst = mr;
    r.rm = rm; r.pm = 8'(pm); r.ra = ra; r.pa = 8'(pa);
    r.chg = chg; r.pa2 = 8'(pa2);
    r.e_am = eam; r.e_aa = eaa; r.e_cur = 8'(ecur); r.e_busy = eb; r.e_hi = ehi;
    return r;
  endfunction

  task automatic chk_reset_state(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_pwm"}, int'(pwm), 0);
    chk({tag, "_cur"}, int'(cur_pos), 128);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_acks"}, int'({ack_m, ack_a}), 0);
  endtask

  task automatic run_row(input row_t r, input int idx);
    row_t e;
    int   w, hi, bad, cur1, busy1, am, aa;
    bit   exp_hi_now;
    if (r.do_rst) begin
      rst = 1'b1; req_m = 1'b0; req_a = 1'b0;
      repeat (3) @(negedge clk);
    end
    if (r.rm) begin req_m = 1'b1; pos_m = r.pm; end
    if (r.ra) begin req_a = 1'b1; pos_a = r.pa; end
    sb.push_back(r);
    @(negedge clk);
    if (r.chg) pos_a = r.pa2;
    if (r.do_rst) begin
      chk_reset_state($sformatf("r%0d_rst", idx));
      rst = 1'b0;
    end
    w = 0;
    while (state != 2'd1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("r%0d_load_lat", idx), w, 1);
    am = int'(ack_m);
    aa = int'(ack_a);
    e  = sb.pop_front();
    @(posedge clk);
    #1;
    if (am != 0) req_m = 1'b0;
    if (aa != 0) req_a = 1'b0;
    hi = 0; bad = 0; cur1 = 0; busy1 = 0;
    for (int i = 1; i <= P - 2; i++) begin
      @(negedge clk);
      if (i == 1) begin cur1 = int'(cur_pos); busy1 = int'(busy); end
      hi += int'(pwm);
      exp_hi_now = (i <= e.e_hi);
      if (pwm != exp_hi_now || state != (exp_hi_now ? 2'd2 : 2'd3) || ack_m || ack_a)
        bad++;
      if (e.mid_rst && i == 100) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state($sformatf("r%0d_midrst", idx));
        break;
      end
    end
    chk($sformatf("r%0d_ack_m", idx), am, int'(e.e_am));
    chk($sformatf("r%0d_ack_a", idx), aa, int'(e.e_aa));
    chk($sformatf("r%0d_cur_pos", idx), cur1, int'(e.e_cur));
    chk($sformatf("r%0d_busy", idx), busy1, int'(e.e_busy));
    chk($sformatf("r%0d_pwm_high", idx), hi, e.e_hi);
    chk($sformatf("r%0d_frame_shape_errs", idx), bad, 0);
  endtask

  initial begin
    //             rst mid rm pm  ra pa   chg pa2 am aa cur busy hi
    tbl.push_back(mk(1, 0, 0, 0,  0, 0,   0, 0,  0, 0, 128, 0, 178));
    tbl.push_back(mk(0, 0, 0, 0,  1, 200, 0, 0,  0, 1, 144, 1, 194));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 160, 1, 210));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 176, 1, 226));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 192, 1, 242));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0,   0, 0,  0, 0, 200, 0, 100));
    tbl.push_back(mk(1, 0, 1, 0,  1, 255, 0, 0,  1, 0, 112, 1, 162));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 1, 128, 1, 178));
    tbl.push_back(mk(1, 0, 0, 0,  1, 120, 0, 0,  0, 1, 120, 0, 170));
    tbl.push_back(mk(0, 0, 0, 0,  1, 250, 0, 0,  0, 1, 136, 1, 186));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 152, 1, 202));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 168, 1, 218));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 184, 1, 234));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 200, 1, 250));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 216, 1, 266));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 232, 1, 282));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 248, 1, 298));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 250, 0, 300));
    tbl.push_back(mk(0, 0, 0, 0,  1, 255, 0, 0,  0, 1, 255, 0, 305));
    tbl.push_back(mk(0, 0, 0, 0,  1, 10,  1, 90, 0, 1, 239, 1, 289));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 0, 223, 1, 273));
    tbl.push_back(mk(0, 0, 1, 50, 1, 60,  0, 0,  1, 0, 207, 1, 257));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0,   0, 0,  0, 1, 191, 1, 241));

    foreach (tbl[k]) run_row(tbl[k], k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
